// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: synchronise, glitch-filter, x4 decode into step/dir and a wrapping count.
// Pin change to step/count/dir = SYNC_STAGES + FILTER_LEN + 1 cycles; no backpressure, every accepted edge is reported.
module quad_encoder_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             sync_ab;
    logic [1:0]             sync_last;
    logic [1:0]             filt;
    logic [CW-1:0]          run_cnt;
    logic [CW-1:0]          run_len;
    logic                   accept;

    logic [0:0]             state;
    logic [1:0]             prev;
    logic                   is_up;
    logic                   is_down;
    logic                   is_bad;
    logic                   do_up;
    logic                   do_down;
    logic                   do_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    end

    assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // A run only grows while the synchronised value holds still; any change restarts it at 1.
    always_comb begin
        run_len = (sync_ab != sync_last) ? CW'(1) : run_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_last <= '0;
            filt      <= '0;
            run_cnt   <= '0;
            accept    <= 1'b0;
        end else begin
            sync_last <= sync_ab;
            accept    <= 1'b0;
            if (sync_ab == filt) begin
                run_cnt <= '0;
            end else if (run_len >= CW'(FILTER_LEN)) begin
                filt    <= sync_ab;
                accept  <= 1'b1;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_len;
            end
        end
    end

    // State is {A,B}; CW order is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        is_up   = 1'b0;
        is_down = 1'b0;
        is_bad  = 1'b0;
        case ({prev, filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up   = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_down = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: is_bad  = 1'b1;
            default: ;
        endcase
    end

    assign do_up   = accept && (state == S_RUN) && is_up;
    assign do_down = accept && (state == S_RUN) && is_down;
    assign do_bad  = accept && (state == S_RUN) && is_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            prev  <= '0;
            count <= '0;
            dir   <= 1'b1;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= do_up || do_down;
            if (accept) begin
                prev  <= filt;
                state <= S_RUN;
            end
            if (do_up) begin
                dir <= 1'b1;
            end else if (do_down) begin
                dir <= 1'b0;
            end
            if (clr) begin
                count <= '0;
            end else if (do_up) begin
                count <= count + WIDTH'(1);
            end else if (do_down) begin
                count <= count - WIDTH'(1);
            end
            // A new illegal transition beats a simultaneous clear request.
            if (do_bad) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
